// File: rtl/mule_issue_arbiter.sv
// Round-robin arbiter that shares the multi-cycle MULE unit between the two issue pipes,
// sequencing one operation at a time from grant through unit handshake to writeback.
module mule_issue_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid_i,
  input  logic [31:0] req0_ra_i,
  input  logic [31:0] req0_rb_i,
  input  logic [4:0]  req0_rd_i,
  output logic        req0_accept_o,
  input  logic        req1_valid_i,
  input  logic [31:0] req1_ra_i,
  input  logic [31:0] req1_rb_i,
  input  logic [4:0]  req1_rd_i,
  output logic        req1_accept_o,
  output logic        unit_valid_o,
  output logic [31:0] unit_ra_o,
  output logic [31:0] unit_rb_o,
  input  logic        unit_accept_i,
  input  logic        unit_done_i,
  input  logic [31:0] unit_result_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_value_o,
  output logic        wb_pipe_o,
  input  logic        wb_accept_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic [4:0]  pending_rd_o,
  output logic        timeout_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_e;

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          discard_q, discard_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   ra_q, ra_d, rb_q, rb_d, result_q, result_d;
  logic [4:0]    rd_q, rd_d;
  logic          pipe_q, pipe_d;
  logic          grant0, grant1, timeout_hit;

  // On a tie the pipe that did not win last time is granted.
  always_comb begin
    grant0      = (state_q == IDLE) && !flush_i && req0_valid_i && (!req1_valid_i || last_grant_q);
    grant1      = (state_q == IDLE) && !flush_i && req1_valid_i && (!req0_valid_i || !last_grant_q);
    timeout_hit = (state_q == WAIT) && !unit_done_i && (cnt_q == CNT_LAST);
  end

  // NOTE: reset is sampled on the clock edge, and every register is cleared, latches included.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      discard_q    <= 1'b0;
      cnt_q        <= '0;
      ra_q         <= '0;
      rb_q         <= '0;
      rd_q         <= '0;
      pipe_q       <= 1'b0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      discard_q    <= discard_d;
      cnt_q        <= cnt_d;
      ra_q         <= ra_d;
      rb_q         <= rb_d;
      rd_q         <= rd_d;
      pipe_q       <= pipe_d;
      result_q     <= result_d;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    discard_d    = discard_q;
    cnt_d        = cnt_q;
    ra_d         = ra_q;
    rb_d         = rb_q;
    rd_d         = rd_q;
    pipe_d       = pipe_q;
    result_d     = result_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          state_d      = ISSUE;
          last_grant_d = grant1;
          pipe_d       = grant1;
          ra_d         = grant1 ? req1_ra_i : req0_ra_i;
          rb_d         = grant1 ? req1_rb_i : req0_rb_i;
          rd_d         = grant1 ? req1_rd_i : req0_rd_i;
          discard_d    = 1'b0;
        end
      end
      ISSUE: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (unit_accept_i) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (flush_i) discard_d = 1'b1;
        // A flush in the done cycle still drops the result.
        if (unit_done_i) begin
          result_d = unit_result_i;
          state_d  = (rd_q != '0 && !discard_q && !flush_i) ? WB : IDLE;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      WB: begin
        if (flush_i || wb_accept_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Every output is forced to zero while reset is held.
  always_comb begin
    req0_accept_o = rst && grant0;
    req1_accept_o = rst && grant1;
    unit_valid_o  = rst && (state_q == ISSUE) && !flush_i;
    unit_ra_o     = rst ? ra_q : '0;
    unit_rb_o     = rst ? rb_q : '0;
    wb_valid_o    = rst && (state_q == WB) && !flush_i;
    wb_rd_o       = rst ? rd_q : '0;
    wb_value_o    = rst ? result_q : '0;
    wb_pipe_o     = rst && pipe_q;
    busy_o        = rst && (state_q != IDLE);
    pending_rd_o  = (rst && (state_q != IDLE)) ? rd_q : '0;
    timeout_o     = rst && timeout_hit;
  end

endmodule

// File: tb/tb_mule_issue_arbiter.sv
// Directed bench for mule_issue_arbiter: stimulus pushes expected grants, issues and
// writebacks into queues; negedge monitors pop and compare as the DUT presents them.
module tb_mule_issue_arbiter;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] val;
    logic        pipe;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic [31:0] req0_ra_i = '0, req0_rb_i = '0, req1_ra_i = '0, req1_rb_i = '0;
  logic [4:0]  req0_rd_i = '0, req1_rd_i = '0;
  logic        req0_accept_o, req1_accept_o;
  logic        unit_valid_o;
  logic [31:0] unit_ra_o, unit_rb_o;
  logic        unit_accept_i = 1'b0, unit_done_i = 1'b0;
  logic [31:0] unit_result_i = '0;
  logic        wb_valid_o, wb_pipe_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_value_o;
  logic        wb_accept_i = 1'b0, flush_i = 1'b0;
  logic        busy_o, timeout_o;
  logic [4:0]  pending_rd_o;

  int tests_run = 0;
  int tests_failed = 0;
  int busy_cnt = 0;
  int to_seen = 0;
  int to_exp = 0;

  bit          exp_grant[$];
  logic [63:0] exp_issue[$];
  wb_t         exp_wb[$];

  mule_issue_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid_i), .req0_ra_i(req0_ra_i), .req0_rb_i(req0_rb_i),
    .req0_rd_i(req0_rd_i), .req0_accept_o(req0_accept_o),
    .req1_valid_i(req1_valid_i), .req1_ra_i(req1_ra_i), .req1_rb_i(req1_rb_i),
    .req1_rd_i(req1_rd_i), .req1_accept_o(req1_accept_o),
    .unit_valid_o(unit_valid_o), .unit_ra_o(unit_ra_o), .unit_rb_o(unit_rb_o),
    .unit_accept_i(unit_accept_i), .unit_done_i(unit_done_i), .unit_result_i(unit_result_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_value_o(wb_value_o),
    .wb_pipe_o(wb_pipe_o), .wb_accept_i(wb_accept_i), .flush_i(flush_i),
    .busy_o(busy_o), .pending_rd_o(pending_rd_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Grant monitor.
  always @(negedge clk) begin
    if (req0_accept_o || req1_accept_o) begin
      if (req0_accept_o && req1_accept_o) begin
        check("grant_exclusive", 64'(2'b11), 64'(2'b01));
      end else if (exp_grant.size() == 0) begin
        check("grant_unexpected", 64'(req1_accept_o), 64'hdead);
      end else begin
        check("grant_pipe", 64'(req1_accept_o), 64'(exp_grant[0]));
        void'(exp_grant.pop_front());
      end
    end
  end

  // Issue monitor: operands must match the queued op on every presented cycle.
  always @(negedge clk) begin
    if (unit_valid_o) begin
      if (exp_issue.size() == 0) begin
        check("issue_unexpected", {unit_ra_o, unit_rb_o}, 64'hdead);
      end else begin
        check("issue_operands", {unit_ra_o, unit_rb_o}, exp_issue[0]);
        if (unit_accept_i) void'(exp_issue.pop_front());
      end
    end
  end

  // Writeback monitor: payload is compared every valid cycle, popped on accept.
  always @(negedge clk) begin
    if (wb_valid_o) begin
      if (exp_wb.size() == 0) begin
        check("wb_unexpected", 64'({wb_rd_o, wb_value_o, wb_pipe_o}), 64'hdead);
      end else begin
        check("wb_payload", 64'({wb_rd_o, wb_value_o, wb_pipe_o}), 64'(exp_wb[0]));
        if (wb_accept_i) void'(exp_wb.pop_front());
      end
    end
    if (busy_o) busy_cnt++;
    if (timeout_o) to_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input bit pipe, input bit v, input logic [31:0] ra,
                         input logic [31:0] rb, input logic [4:0] rd);
    if (!pipe) begin
      req0_valid_i = v; req0_ra_i = ra; req0_rb_i = rb; req0_rd_i = rd;
    end else begin
      req1_valid_i = v; req1_ra_i = ra; req1_rb_i = rb; req1_rd_i = rd;
    end
  endtask

  // Full operation from an IDLE cycle; returns on the IDLE cycle after completion.
  task automatic run_op(input bit pipe, input logic [31:0] ra, input logic [31:0] rb,
                        input logic [4:0] rd, input logic [31:0] res, input int acc_wait,
                        input int done_lat, input int wb_wait, input bit keep);
    set_req(pipe, 1'b1, ra, rb, rd);
    exp_grant.push_back(pipe);
    exp_issue.push_back({ra, rb});
    if (rd != 5'd0) exp_wb.push_back(wb_t'{rd: rd, val: res, pipe: pipe});
    tick();
    if (!keep) begin
      if (!pipe) req0_valid_i = 1'b0; else req1_valid_i = 1'b0;
    end
    settle();
    check("issue_valid_t1", 64'(unit_valid_o), 64'd1);
    check("pending_rd", 64'(pending_rd_o), 64'(rd));
    repeat (acc_wait) tick();
    unit_accept_i = 1'b1;
    tick();
    unit_accept_i = 1'b0;
    repeat (done_lat - 1) tick();
    unit_done_i = 1'b1;
    unit_result_i = res;
    tick();
    unit_done_i = 1'b0;
    if (rd != 5'd0) begin
      for (int i = 0; i <= wb_wait; i++) begin
        if (i == wb_wait) wb_accept_i = 1'b1;
        settle();
        check("wb_valid_held", 64'(wb_valid_o), 64'd1);
        tick();
      end
      wb_accept_i = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    // Reset: requests during reset must not be accepted.
    rst = 1'b0;
    req0_valid_i = 1'b1;
    settle();
    check("reset_accept", 64'(req0_accept_o), 64'd0);
    tick(); tick();
    check("reset_busy", 64'(busy_o), 64'd0);
    req0_valid_i = 1'b0;
    rst = 1'b1;
    settle();
    check("idle_busy", 64'(busy_o), 64'd0);
    check("idle_pending", 64'(pending_rd_o), 64'd0);
    check("idle_unit_valid", 64'(unit_valid_o), 64'd0);

    // Dual requests after reset: grant order 0, 1, 0.
    set_req(0, 1'b1, 32'd3, 32'd5, 5'd1);
    set_req(1, 1'b1, 32'd6, 32'd7, 5'd2);
    run_op(0, 32'd3, 32'd5, 5'd1, 32'd15, 0, 1, 0, 1'b1);
    run_op(1, 32'd6, 32'd7, 5'd2, 32'd42, 0, 1, 0, 1'b1);
    run_op(0, 32'd3, 32'd5, 5'd1, 32'd15, 0, 1, 0, 1'b1);
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;

    // Backpressure with pipe0 waiting; pipe1 wins the tie, pipe0 only after IDLE.
    set_req(0, 1'b1, 32'd2, 32'd3, 5'd4);
    run_op(1, 32'd100, 32'd200, 5'd9, 32'd20000, 5, 2, 4, 1'b0);
    run_op(0, 32'd2, 32'd3, 5'd4, 32'd6, 0, 1, 0, 1'b0);

    // Single request, busy exactly for the operation.
    b0 = busy_cnt;
    run_op(0, 32'd7, 32'd9, 5'd13, 32'd63, 0, 3, 0, 1'b0);
    check("single_busy_cycles", 64'(busy_cnt - b0), 64'd5);
    check("single_idle_after", 64'(busy_o), 64'd0);

    // Flush in WAIT: result dropped, rd reported until IDLE.
    set_req(0, 1'b1, 32'd7, 32'd9, 5'd13);
    exp_grant.push_back(1'b0);
    exp_issue.push_back({32'd7, 32'd9});
    tick();
    req0_valid_i = 1'b0;
    unit_accept_i = 1'b1;
    tick();
    unit_accept_i = 1'b0;
    flush_i = 1'b1;
    settle();
    check("flush_wait_pending", 64'(pending_rd_o), 64'd13);
    tick();
    flush_i = 1'b0;
    tick();
    unit_done_i = 1'b1;
    unit_result_i = 32'd63;
    tick();
    unit_done_i = 1'b0;
    settle();
    check("flush_wait_idle", 64'(busy_o), 64'd0);
    check("flush_wait_pending0", 64'(pending_rd_o), 64'd0);

    // Flush in ISSUE: nothing presented, IDLE next.
    set_req(1, 1'b1, 32'd11, 32'd12, 5'd7);
    exp_grant.push_back(1'b1);
    tick();
    req1_valid_i = 1'b0;
    flush_i = 1'b1;
    settle();
    check("flush_issue_valid", 64'(unit_valid_o), 64'd0);
    tick();
    flush_i = 1'b0;
    settle();
    check("flush_issue_idle", 64'(busy_o), 64'd0);

    // Done and flush in the same cycle: discarded.
    set_req(1, 1'b1, 32'd2, 32'd2, 5'd3);
    exp_grant.push_back(1'b1);
    exp_issue.push_back({32'd2, 32'd2});
    tick();
    req1_valid_i = 1'b0;
    unit_accept_i = 1'b1;
    tick();
    unit_accept_i = 1'b0;
    unit_done_i = 1'b1;
    flush_i = 1'b1;
    unit_result_i = 32'd4;
    tick();
    unit_done_i = 1'b0;
    flush_i = 1'b0;
    settle();
    check("done_flush_idle", 64'(busy_o), 64'd0);

    // Timeout: single pulse in the 8th WAIT cycle, then normal service.
    set_req(0, 1'b1, 32'd1, 32'd1, 5'd5);
    exp_grant.push_back(1'b0);
    exp_issue.push_back({32'd1, 32'd1});
    to_exp++;
    tick();
    req0_valid_i = 1'b0;
    unit_accept_i = 1'b1;
    tick();
    unit_accept_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      settle();
      check("timeout_pulse", 64'(timeout_o), 64'(i == 7));
      tick();
    end
    settle();
    check("timeout_idle", 64'(busy_o), 64'd0);
    check("timeout_low_after", 64'(timeout_o), 64'd0);
    run_op(1, 32'd4, 32'd4, 5'd6, 32'd16, 0, 1, 0, 1'b0);

    // rd = 0 executes without writeback.
    run_op(0, 32'd5, 32'd5, 5'd0, 32'd25, 0, 2, 0, 1'b0);
    settle();
    check("rd0_idle", 64'(busy_o), 64'd0);

    // Reset during WAIT abandons the op; late done is ignored.
    set_req(1, 1'b1, 32'd8, 32'd8, 5'd20);
    exp_grant.push_back(1'b1);
    exp_issue.push_back({32'd8, 32'd8});
    tick();
    req1_valid_i = 1'b0;
    unit_accept_i = 1'b1;
    tick();
    unit_accept_i = 1'b0;
    tick();
    rst = 1'b0;
    req0_valid_i = 1'b1;
    settle();
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_pending", 64'(pending_rd_o), 64'd0);
    check("rst_accept", 64'(req0_accept_o), 64'd0);
    check("rst_unit_ra", 64'(unit_ra_o), 64'd0);
    tick();
    rst = 1'b1;
    req0_valid_i = 1'b0;
    settle();
    check("post_rst_busy", 64'(busy_o), 64'd0);
    check("post_rst_ra_cleared", 64'(unit_ra_o), 64'd0);
    unit_done_i = 1'b1;
    unit_result_i = 32'd99;
    tick();
    unit_done_i = 1'b0;
    settle();
    check("stray_done_ignored", 64'(busy_o | wb_valid_o), 64'd0);
    tick(); tick();

    check("grant_queue_drained", 64'(exp_grant.size()), 64'd0);
    check("issue_queue_drained", 64'(exp_issue.size()), 64'd0);
    check("wb_queue_drained", 64'(exp_wb.size()), 64'd0);
    check("timeout_count", 64'(to_seen), 64'(to_exp));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mule_issue_arbiter.md
# mule_issue_arbiter

Shares the single multi-cycle MULE (extended multiply) unit between the two issue pipes of `riscv_core`. It arbitrates pipe0/pipe1 requests round-robin and sequences one operation at a time through the unit with a valid/accept and done handshake. It returns the result on the dedicated MULE writeback port with the destination register and originating pipe tag. It also exposes the pending destination register for issue-stage hazard checks, and supports flush and watchdog timeout.

## Interface
- `TIMEOUT`, 64: maximum cycles in WAIT before aborting; counter width is `$clog2(TIMEOUT+1)`.
- `clk  in  1  clock`
- `rst  in  1  reset, synchronous, active-low`
- `req0_valid_i / req1_valid_i  in  1  pipe0/pipe1 MULE request`
- `req0_ra_i, req0_rb_i / req1_ra_i, req1_rb_i  in  32  operands`
- `req0_rd_i / req1_rd_i  in  5  destination register`
- `req0_accept_o / req1_accept_o  out  1  request taken this cycle`
- `unit_valid_o  out  1  operation presented to MULE unit`
- `unit_ra_o, unit_rb_o  out  32  latched operands`
- `unit_accept_i  in  1  unit took operation`
- `unit_done_i  in  1  result valid (single-cycle pulse)`
- `unit_result_i  in  32  unit result`
- `wb_valid_o  out  1  writeback request`
- `wb_rd_o  out  5  writeback register`
- `wb_value_o  out  32  writeback data`
- `wb_pipe_o  out  1  originating pipe (0/1)`
- `wb_accept_i  in  1  writeback port consumed result`
- `flush_i  in  1  pipeline flush; cancel in-flight operation`
- `busy_o  out  1  state != IDLE`
- `pending_rd_o  out  5  rd of in-flight op; 0 when idle`
- `timeout_o  out  1  one-cycle pulse on watchdog abort`

## Operation
- FSM states: IDLE, ISSUE, WAIT, WB.
- IDLE: grant one requester if `!flush_i`. If only one is valid, it wins. If both are valid, the one not granted last wins. The granted `reqN_accept_o` is combinationally high. On grant, latch ra/rb/rd/pipe, flip `last_grant` to the granted index, and go to ISSUE. Accept outputs are 0 in every other state.
- ISSUE: `unit_valid_o = !flush_i`.
  - `flush_i` -> IDLE, nothing issued.
  - `unit_accept_i` -> WAIT; clear the timeout counter.
  - Otherwise hold operands stable.
- WAIT: the counter increments each cycle.
  - `unit_done_i` latches `unit_result_i`. The next state is WB if rd != 0 and no discard is pending; otherwise IDLE.
  - `flush_i` sets a discard flag. The op completes in the unit, but its result is dropped on done.
  - If the counter reaches `TIMEOUT` before done: pulse `timeout_o` and go to IDLE.
  - If done and flush occur in the same cycle, the result is discarded.
- WB: `wb_valid_o = 1` with the latched rd/value/pipe.
  - `wb_accept_i` -> IDLE.
  - `flush_i` -> IDLE without writeback; `wb_valid_o` is gated low that cycle.
- rd = 0: the operation executes, but the writeback is suppressed.
- `pending_rd_o` equals the latched rd in ISSUE/WAIT/WB and 0 in IDLE. A discarded op still reports its rd until IDLE.
- Reset (`rst == 0`, sampled on clk): state = IDLE; `last_grant` = 1 so pipe0 wins the first tie; discard flag, counter, and latches are cleared. All outputs are 0 while in reset. Reset mid-operation abandons the op with no writeback; the unit is expected to be reset alongside.

## Timing
- Grant in cycle T. `unit_valid_o` is high from T+1.
- With `unit_accept_i` at T+1, WAIT starts at T+2.
- With `unit_done_i` at cycle D ≥ T+2, `wb_valid_o` is high from D+1.
- With `wb_accept_i` at D+1, IDLE is reached at D+2, and the next grant can occur at D+2.
- Best-case occupancy is 4 cycles per operation. The block handles one operation at a time, with no back-to-back overlap.
- `unit_done_i` outside WAIT is ignored.
- `timeout_o` is asserted in the cycle WAIT→IDLE is decided and is 0 otherwise.

## Test plan
- Single request: pipe0, ra=7, rb=9, rd=13. Unit accepts immediately and returns 63 after 3 cycles. Expect `wb_valid_o` with rd=13, value=63, pipe=0, one cycle after done; `busy_o` high for exactly the op duration.
- Simultaneous requests after reset: both pipes valid at the same time. Expect pipe0 granted first, then pipe1 (round-robin). With three back-to-back dual requests, the grant order is 0, 1, 0.
- Backpressure: hold `unit_accept_i` low for 5 cycles, then `wb_accept_i` low for 4 cycles. Expect operands stable and `wb_*` stable throughout; no second grant until IDLE.
- Flush in WAIT: flush, then done returns 63. Expect no `wb_valid_o`, return to IDLE, and `pending_rd_o` 0 afterwards. Flush in ISSUE: expect `unit_valid_o` low that cycle and IDLE next.
- Timeout: with `TIMEOUT`=8, never assert done. Expect a single `timeout_o` pulse after 8 WAIT cycles, then IDLE, and the next request is granted normally.
- rd=0 and reset: an rd=0 request completes with no writeback. Asserting `rst` low during WAIT forces IDLE with all outputs 0 on the next edge.
